// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scancode decoder.
// Latency: none (types, constants and a pure combinational helper only).
// Backpressure: none. The optional ASCII payload is built when PS2_ASCII_EN is defined.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
`ifdef PS2_ASCII_EN
        logic [7:0] ascii;
`endif
    } ps2_event_t;

`ifdef PS2_ASCII_EN
    // Set-2 make code to ASCII; letters honour shift, everything else ignores it.
    function automatic logic [7:0] ps2_ascii_lut(input logic [7:0] code, input logic shift);
        logic [7:0] lc;
        logic       letter;
        lc     = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
            8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
            8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
            8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
            default: letter = 1'b0;
        endcase
        if (letter) begin
            return shift ? (lc - 8'h20) : lc;
        end
        case (code)
            8'h45: lc = 8'h30; 8'h16: lc = 8'h31; 8'h1E: lc = 8'h32; 8'h26: lc = 8'h33;
            8'h25: lc = 8'h34; 8'h2E: lc = 8'h35; 8'h36: lc = 8'h36; 8'h3D: lc = 8'h37;
            8'h3E: lc = 8'h38; 8'h46: lc = 8'h39;
            8'h29: lc = 8'h20;
            8'h5A: lc = 8'h0D;
            8'h66: lc = 8'h08;
            default: lc = 8'h00;
        endcase
        return lc;
    endfunction
`endif

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through FIFO with full/empty and a sticky overflow flag.
// Latency: a push is visible at pop_dat on the cycle after the write edge.
// Backpressure: a push while full (and no pop) is dropped and sets overflow.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign overflow = overflow_q;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer/occupancy/overflow next-state; a pop frees room for a same-cycle push.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = (overflow_q && !clr_overflow) || (push && !do_push);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are only observed through count_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Decodes PS/2 Set-2 byte streams into {ext, break, code} key events (ASCII added with PS2_ASCII_EN).
// Latency: event pushed on the rx_done_tick cycle, visible on ev_* / !empty one cycle later.
// Backpressure: rx_en drops while the event FIFO is full; events arriving anyway are dropped and flagged.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int PREFIX_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    input  logic       rd_en,
    output logic       empty,
    output logic       full,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
`ifdef PS2_ASCII_EN
    output logic [7:0] ev_ascii,
`endif
    input  logic       clr_overflow
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

    dec_state_t state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic       push;
    ps2_event_t push_ev;
    ps2_event_t head_ev;
    logic       shift_held_q, shift_held_d;
    logic       idle_special;
    logic       ext_special;

    // Bytes that carry no key information on their own (ACK, BAT, echo, resend, errors, pause lead-in).
    always_comb begin
        idle_special = (rx_data == BYTE_FA) || (rx_data == BYTE_AA) || (rx_data == BYTE_EE) ||
                       (rx_data == BYTE_FE) || (rx_data == 8'h00)   || (rx_data == 8'hFF) ||
                       (rx_data == BYTE_E1);
        ext_special  = (rx_data >= BYTE_FA);
    end

    // Decoder FSM, prefix timeout and event assembly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        push_ev      = '0;
        shift_held_d = shift_held_q;
        if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == BYTE_E0) begin
                        state_d = EXT;
                    end else if (rx_data == BYTE_F0) begin
                        state_d = BRK;
                    end else if (!idle_special) begin
                        push = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == BYTE_F0) begin
                        state_d = EXT_BRK;
                    end else if (rx_data == BYTE_E0) begin
                        state_d = EXT;
                    end else begin
                        state_d     = IDLE;
                        push        = !ext_special;
                        push_ev.ext = 1'b1;
                    end
                end
                BRK: begin
                    state_d     = IDLE;
                    push        = (rx_data != BYTE_E0) && (rx_data != BYTE_F0);
                    push_ev.brk = 1'b1;
                end
                default: begin
                    state_d     = IDLE;
                    push        = (rx_data != BYTE_E0) && (rx_data != BYTE_F0);
                    push_ev.ext = 1'b1;
                    push_ev.brk = 1'b1;
                end
            endcase
            push_ev.code = rx_data;
        end else if (state_q != IDLE) begin
            if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
        if (!push) begin
            push_ev = '0;
        end
`ifdef PS2_ASCII_EN
        // Shift tracking follows the keyboard even when the event itself is dropped on overflow.
        if (push && !push_ev.ext) begin
            if (!push_ev.brk) begin
                push_ev.ascii = ps2_ascii_lut(push_ev.code, shift_held_q);
            end
            if ((push_ev.code == 8'h12) || (push_ev.code == 8'h59)) begin
                shift_held_d = !push_ev.brk;
            end
        end
`endif
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_held_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_held_q <= shift_held_d;
        end
    end

    ps2_event_fifo #(
        .WIDTH($bits(ps2_event_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .push_dat     (push_ev),
        .pop          (rd_en),
        .pop_dat      (head_ev),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    assign rx_en    = ~full;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_break = head_ev.brk;
`ifdef PS2_ASCII_EN
    assign ev_ascii = head_ev.ascii;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder (ASCII scenario included when PS2_ASCII_EN is defined).
// Expected events are queued as bytes are driven and compared as the FIFO is drained.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       rd_en = 1'b0;
    logic       empty;
    logic       full;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [7:0] ev_ascii_w;

    int checks = 0;
    int passed = 0;

    // {ext, brk, code, ascii}
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH(DEPTH),
        .PREFIX_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .rd_en        (rd_en),
        .empty        (empty),
        .full         (full),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .overflow     (overflow),
`ifdef PS2_ASCII_EN
        .ev_ascii     (ev_ascii_w),
`endif
        .clr_overflow (clr_overflow)
    );
`ifndef PS2_ASCII_EN
    assign ev_ascii_w = 8'h00;
`endif

    task automatic tick(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code,
                             input logic [7:0] ascii);
        exp_q.push_back({ext, brk, code, ascii});
    endtask

    // Pops every queued expectation off the DUT and compares head fields, then checks empty.
    task automatic drain(input string name);
        logic [17:0] e;
        int w;
        while (exp_q.size() > 0) begin
            w = 0;
            while (empty && w < 20) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (empty) begin
                $display("FAIL %s: timeout waiting for event, empty=%0b required 0", name, empty);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
`ifdef PS2_ASCII_EN
                if ({ev_ext, ev_break, ev_code, ev_ascii_w} !== e)
`else
                if ({ev_ext, ev_break, ev_code} !== e[17:8])
`endif
                    $display("FAIL %s: event got ext=%0b brk=%0b code=%h ascii=%h required ext=%0b brk=%0b code=%h ascii=%h",
                             name, ev_ext, ev_break, ev_code, ev_ascii_w, e[17], e[16], e[15:8], e[7:0]);
                else
                    passed++;
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        end
        checks++;
        if (empty !== 1'b1) $display("FAIL %s: empty after drain got %0b required 1", name, empty);
        else passed++;
    endtask

    task automatic test_reset();
        checks++;
        if ({empty, full, rx_en, overflow, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset: empty=%0b full=%0b rx_en=%0b ovf=%0b ev=%0b%0b%h required 1 0 1 0 00 00",
                     empty, full, rx_en, overflow, ev_ext, ev_break, ev_code);
        else passed++;
    endtask

    task automatic test_make();
        tick(8'h1C);
        expect_ev(1'b0, 1'b0, 8'h1C, 8'h00);
        checks++;
        if (empty !== 1'b0) $display("FAIL make_latency: empty got %0b required 0", empty);
        else passed++;
        drain("make");
    endtask

    task automatic test_ext_break();
        tick(8'hE0);
        tick(8'hF0);
        checks++;
        if (empty !== 1'b1) $display("FAIL prefix_no_push: empty got %0b required 1", empty);
        else passed++;
        tick(8'h75);
        expect_ev(1'b1, 1'b1, 8'h75, 8'h00);
        drain("ext_break");
        // specials discarded in IDLE, repeated E0 stays extended, malformed F0 F0 dropped
        tick(8'hFA);
        tick(8'hAA);
        tick(8'hE0);
        tick(8'hE0);
        tick(8'h70);
        expect_ev(1'b1, 1'b0, 8'h70, 8'h00);
        tick(8'hF0);
        tick(8'hF0);
        tick(8'h2C);
        expect_ev(1'b0, 1'b0, 8'h2C, 8'h00);
        drain("specials");
    endtask

    task automatic test_timeout();
        // one cycle short of the timeout: the break prefix survives
        tick(8'hF0);
        repeat (TMO - 1) @(negedge clk);
        tick(8'h1C);
        expect_ev(1'b0, 1'b1, 8'h1C, 8'h00);
        drain("timeout_edge");
        // full timeout: prefix abandoned
        tick(8'hF0);
        repeat (TMO) @(negedge clk);
        tick(8'h1C);
        expect_ev(1'b0, 1'b0, 8'h1C, 8'h00);
        drain("timeout");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        for (int i = 0; i < 9; i++) begin
            tick(codes[i]);
            if (i < DEPTH) expect_ev(1'b0, 1'b0, codes[i], 8'h00);
            if (i == DEPTH - 1) begin
                checks++;
                if ({full, rx_en, overflow} !== 3'b100)
                    $display("FAIL full_no_ovf: full=%0b rx_en=%0b ovf=%0b required 1 0 0", full, rx_en, overflow);
                else passed++;
            end
        end
        checks++;
        if ({full, rx_en, overflow} !== 3'b101)
            $display("FAIL overflow: full=%0b rx_en=%0b ovf=%0b required 1 0 1", full, rx_en, overflow);
        else passed++;
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) $display("FAIL clr_overflow: ovf got %0b required 0", overflow);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        // FIFO is still full from the overflow scenario
        e = exp_q.pop_front();
        checks++;
        if ({ev_ext, ev_break, ev_code} !== e[17:8])
            $display("FAIL b2b_head: code got %h required %h", ev_code, e[15:8]);
        else passed++;
        rd_en = 1'b1;
        expect_ev(1'b0, 1'b0, 8'h4D, 8'h00);
        tick(8'h4D);
        rd_en = 1'b0;
        checks++;
        if ({full, overflow} !== 2'b10)
            $display("FAIL b2b_occupancy: full=%0b ovf=%0b required 1 0", full, overflow);
        else passed++;
        drain("b2b_order");
    endtask

    task automatic test_ascii();
`ifdef PS2_ASCII_EN
        tick(8'h12);
        tick(8'h1C);
        tick(8'hF0);
        tick(8'h12);
        tick(8'h1C);
        expect_ev(1'b0, 1'b0, 8'h12, 8'h00);
        expect_ev(1'b0, 1'b0, 8'h1C, 8'h41);
        expect_ev(1'b0, 1'b1, 8'h12, 8'h00);
        expect_ev(1'b0, 1'b0, 8'h1C, 8'h61);
        tick(8'h5A);
        expect_ev(1'b0, 1'b0, 8'h5A, 8'h0D);
        drain("ascii");
`endif
    endtask

    task automatic test_mid_reset();
        tick(8'h2C);
        tick(8'hE0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({empty, full, overflow, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h00})
            $display("FAIL mid_reset: empty=%0b full=%0b ovf=%0b code=%h required 1 0 0 00",
                     empty, full, overflow, ev_code);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tick(8'h1C);
        expect_ev(1'b0, 1'b0, 8'h1C, 8'h00);
        drain("post_reset");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_make();
        test_ext_break();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_ascii();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
